// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serial FSM encoding.
package mmio_uart_tx_pkg;

    localparam logic [15:0] TXDATA_OFS = 16'h0000;
    localparam logic [15:0] STATUS_OFS = 16'h0004;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus slice seen by the UART: store strobe, address, data and
// the combinational load/hit responses.
interface mmio_uart_tx_if;
    logic        memWrite;
    logic [15:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        sel;

    modport master (
        output memWrite, addr, writeData,
        input  readData, sel
    );

    modport slave (
        input  memWrite, addr, writeData,
        output readData, sel
    );
endinterface

// File: rtl/mmio_uart_tx_core.sv
// 8N1 serial engine: pops one byte per frame from a valid/ready source and
// shifts it out LSB first; frames chain with no idle gap when data is waiting.
module uart_tx_core
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        ready   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready  = 1'b1;
                baud_d = '0;
                if (valid) begin
                    shift_d = data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    // Pop here so the next start bit follows the stop bit directly.
                    ready = 1'b1;
                    if (valid) begin
                        shift_d = data;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == S_START)     tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = shift_d[0];
    end

    assign busy = (state_q != S_IDLE);
    assign tx   = tx_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores feed a small FIFO drained by
// uart_tx_core; STATUS reports full/empty/busy and a sticky overflow flag.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic        is_status, full, empty, busy;
    logic        push_req, push_ok, pop, ovf_clr;
    logic        core_ready;
    logic [31:0] status;
    logic        unused_bits;

    assign bus.sel   = (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign is_status = (bus.addr[2] == STATUS_OFS[2]);

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);

    assign push_req = bus.memWrite & bus.sel & ~is_status;
    assign pop      = ~empty & core_ready;
    // A full FIFO still accepts when the engine drains an entry in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_clr  = bus.memWrite & bus.sel & is_status & bus.writeData[STAT_OVF];

    always_comb begin
        wptr_d = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop     ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
        ovf_d = ovf_q;
        if (push_req && !push_ok) ovf_d = 1'b1;
        else if (ovf_clr)         ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) fifo_q[wptr_q] <= bus.writeData[7:0];
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .valid (~empty),
        .data  (fifo_q[rptr_q]),
        .ready (core_ready),
        .busy  (busy),
        .tx    (tx)
    );

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = full;
        status[STAT_EMPTY] = empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = ovf_q;
    end

    assign bus.readData = (bus.sel && is_status) ? status : 32'h0;

    assign unused_bits = ^{bus.addr[1:0], bus.writeData[31:8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bytes expected on the line are queued as
// they are stored, and a line monitor decodes each 8N1 frame against the queue.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR    (16'hFF00),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int         ncomp = 0;
    int         nfail = 0;
    int         cyc   = 0;
    logic [7:0] sb[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are applied now, sampled at the next rising edge; returns 1ns after it.
    task automatic drive(input logic we, input logic [15:0] a, input logic [31:0] d);
        bus.memWrite  = we;
        bus.addr      = a;
        bus.writeData = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'hFF04, 32'h0);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] v);
        bus.memWrite = 1'b0;
        bus.addr     = a;
        #1;
        v = bus.readData;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        do begin
            drive(1'b0, 16'hFF04, 32'h0);
            w++;
        end while (bus.readData[2] && w < 600);
        chk(tag, (w < 600) ? 1 : 0, 1);
        idle(4);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    // Line monitor: cnt counts falling edges since the first low sample of a start bit.
    initial begin
        int         cnt;
        logic [7:0] b;
        cnt = -1;
        b   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = -1;
            end else if (cnt < 0) begin
                if (tx === 1'b0) begin
                    cnt = 0;
                    b   = '0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == 2) chk("start_bit", tx, 0);
                if (cnt >= 6 && cnt <= 34 && (cnt - 6) % 4 == 0) b[(cnt - 6) / 4] = tx;
                if (cnt == 38) begin
                    chk("stop_bit", tx, 1);
                    chk("frame_expected", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) chk("frame_byte", b, sb.pop_front());
                    cnt = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        int          nb, nl;

        bus.memWrite  = 1'b0;
        bus.addr      = 16'hFF04;
        bus.writeData = 32'h0;

        // Reset state and address decode
        idle(2);
        chk("rst_tx", tx, 1);
        rst = 1'b0;
        rd(16'hFF04, st);
        chk("rst_status", st, 32'h2);
        chk("sel_status", bus.sel, 1);
        rd(16'hFF00, st);
        chk("txdata_read", st, 32'h0);
        rd(16'h0100, st);
        chk("offmap_read", st, 32'h0);
        chk("offmap_sel", bus.sel, 0);
        drive(1'b1, 16'h0100, 32'hAA);
        idle(2);
        rd(16'hFF04, st);
        chk("offmap_write_ignored", st, 32'h2);
        chk("offmap_tx", tx, 1);

        // Single frame, busy window
        sb.push_back(8'hA5);
        drive(1'b1, 16'hFF00, 32'h000000A5);
        chk("tx_high_in_push_cycle", tx, 1);
        drive(1'b0, 16'hFF04, 32'h0);
        chk("tx_low_after_pop", tx, 0);
        nb = bus.readData[2] ? 1 : 0;
        repeat (59) begin
            drive(1'b0, 16'hFF04, 32'h0);
            if (bus.readData[2]) nb++;
        end
        chk("single_busy_cycles", nb, 40);
        chk("single_sb_empty", sb.size(), 0);

        // Back-to-back frames
        starts.delete();
        sb.push_back(8'h55);
        sb.push_back(8'hC3);
        drive(1'b1, 16'hFF00, 32'h55);
        drive(1'b1, 16'hFF00, 32'hC3);
        rd(16'hFF04, st);
        nb = st[2] ? 1 : 0;
        for (int i = 0; i < 120; i++) begin
            drive(1'b0, 16'hFF04, 32'h0);
            if (bus.readData[2]) nb++;
            if (i == 48) chk("b2b_status_mid", bus.readData, 32'h6);
        end
        chk("b2b_busy_cycles", nb, 80);
        chk("b2b_frame_count", starts.size(), 2);
        if (starts.size() >= 2) chk("b2b_gap", starts[1] - starts[0], 10 * CPB);
        chk("b2b_sb_empty", sb.size(), 0);

        // Overflow: 01..05 queued/sent, 06 dropped
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) sb.push_back(8'(k));
            drive(1'b1, 16'hFF00, 32'(k));
        end
        rd(16'hFF04, st);
        chk("ovf_status", st, 32'hD);
        drive(1'b1, 16'hFF04, 32'h8);
        rd(16'hFF04, st);
        chk("ovf_cleared", st, 32'h5);
        drain("ovf_drain");

        // Push on full in the STOP-end pop cycle
        for (int k = 1; k <= 5; k++) begin
            sb.push_back(8'(k * 8'h11));
            drive(1'b1, 16'hFF00, 32'(k * 8'h11));
        end
        idle(36);
        rd(16'hFF04, st);
        chk("full_before_pop", st, 32'h5);
        sb.push_back(8'h66);
        drive(1'b1, 16'hFF00, 32'h66);
        rd(16'hFF04, st);
        chk("push_on_pop_status", st, 32'h5);
        drain("pushpop_drain");

        // Mid-frame reset during data bit 3 with two bytes queued
        drive(1'b1, 16'hFF00, 32'hFF);
        drive(1'b1, 16'hFF00, 32'h12);
        drive(1'b1, 16'hFF00, 32'h34);
        idle(16);
        chk("pre_reset_busy", bus.readData[2], 1);
        rst = 1'b1;
        drive(1'b1, 16'hFF00, 32'h77);
        chk("reset_tx", tx, 1);
        rst = 1'b0;
        rd(16'hFF04, st);
        chk("reset_status", st, 32'h2);
        nl = 0;
        repeat (100) begin
            drive(1'b0, 16'hFF04, 32'h0);
            if (tx !== 1'b1) nl++;
        end
        chk("post_reset_line_idle", nl, 0);
        rd(16'hFF04, st);
        chk("post_reset_status", st, 32'h2);
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the processor data bus: the same addr / writeData / memWrite / readData signals the data memory answers.
- Processor stores to TXDATA queue bytes in a small FIFO. A serial engine drains the FIFO as 8N1 frames on tx.
- Processor loads from STATUS poll FIFO, busy and overflow state.
- Sits beside the data memory in the top level; the top level muxes readData between the two using sel.

Parameters:
BASE_ADDR, 16'hFF00, byte address of TXDATA; STATUS at BASE_ADDR+4; must be 8-byte aligned
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
memWrite  input  1  store strobe from processor, qualified by address hit
addr  input  16  data byte address (ALUResult[15:0])
writeData  input  32  store data
readData  output  32  load data, combinational from addr
sel  output  1  combinational address hit: addr[15:3] == BASE_ADDR[15:3]
tx  output  1  serial line, idle high

Behaviour:
- Register map (addr[2]):
  - 0 = TXDATA. Write pushes writeData[7:0]. Read returns 0.
  - 1 = STATUS. Read returns {28'b0, ovf, busy, empty, full}.
  - Write to STATUS with writeData[3]=1 clears ovf; all other STATUS bits are ignored on write.
- addr[1:0] ignored. When sel=0: readData = 0 and writes are ignored.
- Push condition: memWrite & sel & ~addr[2].
  - Accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and ovf is set (sticky).
- Clear/set collision: ovf set and ovf clear in the same cycle cannot happen, because the two use different addresses.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - Count has log2(FIFO_DEPTH)+1 bits.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Simultaneous push and pop leaves count unchanged.
- Serial FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty: pop, load shift register, clear baud counter, go to START.
  - Each of START, DATA-bit and STOP lasts exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1.
  - START: tx=0.
  - DATA: tx = shift[0], LSB first. Shift right and increment bit index at the end of each bit. After bit 7, go to STOP.
  - STOP: tx=1. At its end, if FIFO not empty: pop and go directly to START (back-to-back frames, no idle gap). Else go to IDLE.
- Frame timing: 10*CLKS_PER_BIT cycles.
  - tx goes low on the first edge after the pop cycle, i.e. one cycle after a push into an empty idle FIFO.
  - tx is registered.
- busy = (state != IDLE).
- Reset (also mid-frame) takes effect on the next rising edge:
  - state IDLE, tx=1, FIFO emptied (pointers and count 0), ovf=0, baud counter and bit index 0.
  - A frame in progress is truncated; a write in the reset cycle is ignored.
- Reset output values: tx=1, STATUS reads 32'h2 (empty=1). readData and sel stay combinational.

Decomposition:
- Shared package / header:
  - register offsets (TXDATA_OFS=0, STATUS_OFS=4)
  - STATUS bit indices (FULL=0, EMPTY=1, BUSY=2, OVF=3)
  - FSM state encoding (2-bit localparams)
- One natural sub-module: uart_tx_core.
  - Contains the FSM, baud counter and shift register.
  - Interface: clk, rst, valid, data[7:0], ready (pop strobe = valid & ready), busy, tx.
- FIFO and register decode stay in mmio_uart_tx.

Test Plan:
- Reset check: CLKS_PER_BIT=4; assert rst 2 cycles → tx=1; read STATUS (addr FF04) = 32'h2; read addr FF00 = 0; addr 0100 → sel=0, readData=0.
- Single frame: store 32'h000000A5 to FF00 → tx low one cycle later for 4 cycles; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; then stop high 4 cycles. busy=1 for exactly 40 cycles.
- Back-to-back: store 8'h55 then 8'hC3 on consecutive cycles → the two frames are contiguous (no idle cycle between stop and start) and total 80 cycles. empty=1 after the second pop.
- Overflow: six consecutive stores 01..06 while idle → the first byte pops immediately, 01..05 are transmitted and 06 is dropped. STATUS = 32'hD (busy, ovf, full) after the sixth store. Writing 32'h8 to FF04 clears ovf.
- Push on full with simultaneous pop: fill FIFO while busy; store exactly in the STOP-end pop cycle → byte accepted, ovf stays 0, full stays 1.
- Mid-frame reset: assert rst during DATA bit 3 of frame 8'hFF with two bytes queued → next edge tx=1, STATUS=32'h2, no further frames.
